// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle for uart_rx_param: the held word, its error tags,
// the ready/ack handshake and the overrun pulse.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] uart_word;
    logic                 ready;
    logic                 ack;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output uart_word,
        output ready,
        input  ack,
        output parity_err,
        output frame_err,
        output overrun
    );

    modport slave (
        input  uart_word,
        input  ready,
        output ack,
        input  parity_err,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with configurable word length, parity and stop bits;
// holds one received word with error tags behind a ready/ack handshake.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 2,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             baud_tick,
    input  logic             uart_stream,
    uart_rx_param_if.master  bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1   = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ZERO = TW'(0);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY_ST = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // Expected parity bit for the received data; odd parity is the inverse.
    function automatic logic expected_parity(input logic [DATA_BITS-1:0] d);
        logic even_s;
        even_s = ^d;
        return (PARITY == 1) ? ~even_s : even_s;
    endfunction

    logic [1:0]           sync_r;
    logic                 rx_s;
    state_t               state_r, state_s;
    logic [TW-1:0]        tick_cnt_r, tick_cnt_s;
    logic [3:0]           bit_cnt_r, bit_cnt_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 perr_r, perr_s;
    logic                 ferr_r, ferr_s;
    logic                 deliver_s;
    logic [DATA_BITS-1:0] word_r;
    logic                 ready_r, wperr_r, wferr_r, overrun_r;

    assign rx_s = sync_r[1];

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], uart_stream};
        end
    end

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            tick_cnt_r <= TICK_ZERO;
            bit_cnt_r  <= 4'd0;
            shift_r    <= {DATA_BITS{1'b0}};
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            perr_r     <= perr_s;
            ferr_r     <= ferr_s;
        end
    end

    // Next-state and datapath updates; everything advances only on baud_tick.
    always_comb begin
        state_s    = state_r;
        tick_cnt_s = tick_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        perr_s     = perr_r;
        ferr_s     = ferr_r;
        deliver_s  = 1'b0;
        if (baud_tick) begin
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_s    = START;
                        tick_cnt_s = TICK_ZERO;
                        perr_s     = 1'b0;
                        ferr_s     = 1'b0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                START: begin
                    // Mid-start re-check rejects short glitches.
                    if (tick_cnt_r == HALF_M1) begin
                        tick_cnt_s = TICK_ZERO;
                        bit_cnt_s  = 4'd0;
                        state_s    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                DATA: begin
                    if (tick_cnt_r == FULL_M1) begin
                        tick_cnt_s = TICK_ZERO;
                        shift_s    = {rx_s, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == LAST_DATA) begin
                            bit_cnt_s = 4'd0;
                            state_s   = (PARITY != 0) ? PARITY_ST : STOP;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                PARITY_ST: begin
                    if (tick_cnt_r == FULL_M1) begin
                        tick_cnt_s = TICK_ZERO;
                        perr_s     = (rx_s != expected_parity(shift_r));
                        bit_cnt_s  = 4'd0;
                        state_s    = STOP;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                STOP: begin
                    if (tick_cnt_r == FULL_M1) begin
                        tick_cnt_s = TICK_ZERO;
                        ferr_s     = ferr_r | ~rx_s;
                        if (bit_cnt_r == LAST_STOP) begin
                            deliver_s = 1'b1;
                            bit_cnt_s = 4'd0;
                            state_s   = ferr_s ? BREAK : IDLE;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                BREAK: begin
                    state_s = rx_s ? IDLE : BREAK;
                end
                default: begin
                    state_s    = IDLE;
                    tick_cnt_s = TICK_ZERO;
                    bit_cnt_s  = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Output holding register: delivery wins over a same-cycle take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_r    <= {DATA_BITS{1'b0}};
            ready_r   <= 1'b0;
            wperr_r   <= 1'b0;
            wferr_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (deliver_s && (!ready_r || bus.ack)) begin
                word_r  <= shift_r;
                wperr_r <= perr_r;
                wferr_r <= ferr_s;
                ready_r <= 1'b1;
            end else if (deliver_s) begin
                overrun_r <= 1'b1;
            end else if (ready_r && bus.ack) begin
                ready_r <= 1'b0;
            end
        end
    end

    assign bus.uart_word  = word_r;
    assign bus.ready      = ready_r;
    assign bus.parity_err = wperr_r;
    assign bus.frame_err  = wferr_r;
    assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param at default parameters with baud_tick held high.
module tb_uart_rx_param;

    localparam int OS = 16;

    typedef struct packed {
        logic [7:0] word;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baud_tick = 1'b1;
    logic uart_stream = 1'b1;
    int   pass_cnt = 0;
    int   chk_cnt = 0;
    int   ovr_cnt = 0;
    exp_t exp_q[$];

    uart_rx_param_if #(.DATA_BITS(8)) bus ();

    uart_rx_param #(
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS)
    ) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .uart_stream(uart_stream), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_bit(input logic b);
        uart_stream = b;
        repeat (OS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stp);
    endtask

    task automatic push_exp(input logic [7:0] w, input logic pe, input logic fe);
        exp_t e;
        e.word = w; e.perr = pe; e.ferr = fe;
        exp_q.push_back(e);
    endtask

    // Monitor: every consumed word is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.ready && bus.ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {24'd0, bus.uart_word}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("uart_word", {24'd0, bus.uart_word}, {24'd0, e.word});
                check("parity_err", {31'd0, bus.parity_err}, {31'd0, e.perr});
                check("frame_err", {31'd0, bus.frame_err}, {31'd0, e.ferr});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.overrun) ovr_cnt++;
    end

    initial begin
        bus.ack = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
        check("rst_word", {24'd0, bus.uart_word}, 32'd0);
        check("rst_perr", {31'd0, bus.parity_err}, 32'd0);
        check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
        check("rst_overrun", {31'd0, bus.overrun}, 32'd0);
        rst = 1'b0;
        repeat (2 * OS) @(negedge clk);

        // Clean frame, then a parity mismatch.
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1);
        drive_bit(1'b1);
        push_exp(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b1);
        drive_bit(1'b1);

        // Stop bit low followed by a long break, then a clean frame.
        push_exp(8'h55, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (40) drive_bit(1'b0);
        repeat (2) drive_bit(1'b1);
        push_exp(8'h12, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b1);
        repeat (2) drive_bit(1'b1);

        // Short low glitch must not produce a word.
        uart_stream = 1'b0;
        repeat (4) @(negedge clk);
        uart_stream = 1'b1;
        repeat (3 * OS) @(negedge clk);
        check("glitch_no_ready", {31'd0, bus.ready}, 32'd0);

        // Back-to-back frames without ack: first is held, second overruns.
        bus.ack = 1'b0;
        push_exp(8'h01, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h02, 1'b1, 1'b1);
        drive_bit(1'b1);
        check("held_ready", {31'd0, bus.ready}, 32'd1);
        check("held_word", {24'd0, bus.uart_word}, 32'h01);
        check("overrun_count", ovr_cnt, 32'd1);
        bus.ack = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_cleared", {31'd0, bus.ready}, 32'd0);
        push_exp(8'h03, 1'b0, 1'b0);
        send_frame(8'h03, 1'b0, 1'b1);
        drive_bit(1'b1);

        // Reset in the middle of data bit 4 aborts the frame.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (OS / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * OS) @(negedge clk);
        check("abort_no_ready", {31'd0, bus.ready}, 32'd0);
        push_exp(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (3) drive_bit(1'b1);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("overrun_total", ovr_cnt, 32'd1);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter PARITY, default 2, meaning 0 none, 1 odd, 2 even.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame (legal 1..2).
REQ-004 The block SHALL have parameter OVERSAMPLE, default 16, meaning baud_tick pulses per bit period (even, legal 4..64).
REQ-005 The block SHALL have port clk, input, 1, meaning the single system clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-007 The block SHALL have port baud_tick, input, 1, meaning a one-clk enable pulse at OVERSAMPLE x baud rate.
REQ-008 The block SHALL have port uart_stream, input, 1, meaning asynchronous serial line, idle high.
REQ-009 The block SHALL have port uart_word, output, DATA_BITS, meaning the received word, LSB first on line.
REQ-010 The block SHALL have port ready, output, 1, meaning uart_word and error tags are valid.
REQ-011 The block SHALL have port ack, input, 1, meaning the consumer takes the word when ready && ack.
REQ-012 The block SHALL have port parity_err, output, 1, meaning a parity mismatch tag on the held word.
REQ-013 The block SHALL have port frame_err, output, 1, meaning a stop-bit-low tag on the held word.
REQ-014 The block SHALL have port overrun, output, 1, meaning a one-clk pulse when a completed word is discarded.

Function
REQ-015 uart_stream SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-016 State and counter updates SHALL occur only on clk edges with baud_tick=1, except handshake and output-register logic.
REQ-017 States SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-018 In IDLE, a tick with rx_s=0 SHALL move the FSM to START with tick_cnt cleared.
REQ-019 In START, tick_cnt SHALL increment per tick; at tick_cnt=OVERSAMPLE/2-1, rx_s=0 SHALL go to DATA (tick_cnt=0, bit_cnt=0) and rx_s=1 SHALL return the FSM to IDLE as a glitch.
REQ-020 In DATA, PARITY and STOP, a bit SHALL be sampled when tick_cnt=OVERSAMPLE-1, and tick_cnt SHALL then clear.
REQ-021 DATA SHALL shift DATA_BITS samples LSB first, then go to PARITY if PARITY!=0, otherwise to STOP.
REQ-022 PARITY SHALL compare the sample with even parity (XOR of data) or odd parity (its inverse) and latch the mismatch.
REQ-023 STOP SHALL sample STOP_BITS bits; any low sample SHALL set the frame error.
REQ-024 After the last stop sample, the block SHALL deliver the word and go to IDLE, or to BREAK if the frame error is set.
REQ-025 BREAK SHALL wait for rx_s=1 on a tick, then go to IDLE, so a held-low line yields exactly one frame_err word.
REQ-026 Delivery SHALL load uart_word, parity_err and frame_err and set ready on the next clk, if ready=0 or ack=1 in the delivery cycle.
REQ-027 Otherwise the new word SHALL be discarded, the held word SHALL stay unchanged, and overrun SHALL pulse for one clk.
REQ-028 ready SHALL clear on the clk after ready && ack unless a delivery occurs in the same cycle; that delivery SHALL take priority and keep ready=1.
REQ-029 uart_word, parity_err and frame_err SHALL be stable while ready=1 and ack=0.

Reset
REQ-030 rst=1 SHALL force IDLE, clear all counters, set the synchronizer flops to 1, and set uart_word=0, ready=0, parity_err=0, frame_err=0, overrun=0.
REQ-031 rst asserted mid-frame SHALL abort the frame without delivery; after release the FSM SHALL wait for a new start edge.

Verification (defaults, baud_tick=1 every clk)
REQ-032 Frame 0x A5, even parity bit 0, stop 1, ack held 1 -> one ready pulse, uart_word=0xA5, parity_err=0, frame_err=0.
REQ-033 Frame 0x3C with parity bit 1 -> uart_word=0x3C, parity_err=1, frame_err=0.
REQ-034 Frame 0x55 with stop bit 0, line held low 40 bit-times, then high, then frame 0x12 -> one word 0x55 with frame_err=1, then 0x12 clean, no words from the break.
REQ-035 Low pulse of 4 ticks on an idle line -> no ready, FSM back in IDLE.
REQ-036 Frames 0x01 and 0x02 back-to-back with ack=0 -> ready=1, uart_word=0x01 kept, overrun pulses once; a third frame 0x03 after ack -> uart_word=0x03.
REQ-037 rst asserted at data bit 4 of frame 0xFF, released, then frame 0x81 -> only 0x81 is delivered.
